dadd_unit: RTL



---
 rtl/dadd_unit_pkg.sv | 49 ++++
 rtl/dadd_unit_lane.sv | 29 ++
 rtl/dadd_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/dadd_unit_pkg.sv
// Shared blitter data-adder encodings: operand selects, adder modes, write-back targets
// and the per-half register update helper.
package dadd_unit_pkg;

  localparam int unsigned LANE_W     = 16;
  localparam int unsigned LANE_COUNT = 4;

  localparam logic [2:0] ASEL_DSTD  = 3'b000;
  localparam logic [2:0] ASEL_SRCD  = 3'b001;
  localparam logic [2:0] ASEL_PATF  = 3'b100;
  localparam logic [2:0] ASEL_PATD  = 3'b101;
  localparam logic [2:0] ASEL_SRCZ2 = 3'b110;
  localparam logic [2:0] ASEL_SRCZ1 = 3'b111;

  localparam logic [2:0] BSEL_SRCD    = 3'b000;
  localparam logic [2:0] BSEL_DSTD    = 3'b001;
  localparam logic [2:0] BSEL_IINC_LO = 3'b100;
  localparam logic [2:0] BSEL_IINC_HI = 3'b101;
  localparam logic [2:0] BSEL_ZINC_LO = 3'b110;
  localparam logic [2:0] BSEL_ZINC_HI = 3'b111;

  typedef enum logic [2:0] {
    DMODE_FRAC   = 3'b000,
    DMODE_INT8   = 3'b001,
    DMODE_Z16SAT = 3'b010,
    DMODE_WRAP16 = 3'b011
  } dmode_e;

  typedef enum logic [2:0] {
    WB_NONE, WB_PATF, WB_PATD, WB_SRCZ2, WB_SRCZ1
  } wb_tgt_e;

  // Modes with bit 2 set fall back to fractional behaviour.
  function automatic dmode_e decode_mode(input logic [2:0] m);
    return m[2] ? DMODE_FRAC : dmode_e'(m);
  endfunction

  // GPU load of a 32-bit half wins over the adder write-back to that half.
  function automatic logic [63:0] merge_halves(input logic [63:0] cur, input logic [1:0] ld,
                                               input logic [31:0] din, input logic wr,
                                               input logic [63:0] sum);
    logic [63:0] r;
    r = wr ? sum : cur;
    if (ld[0]) r[31:0]  = din;
    if (ld[1]) r[63:32] = din;
    return r;
  endfunction

endpackage

// File: rtl/dadd_unit_lane.sv
// One 16-bit adder lane: carry-in, mode-dependent saturation and raw carry-out.
module dadd_lane
  import dadd_unit_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              cin,
  input  dmode_e            mode,
  output logic [LANE_W-1:0] sum,
  output logic              cout
);

  logic [LANE_W:0] s;
  logic [9:0]      s8;

  always_comb begin
    s    = {1'b0, a} + {1'b0, b} + {{LANE_W{1'b0}}, cin};
    // Intensity byte: B[15] carries the sign, so B[7:0] extends to a 10-bit signed term.
    s8   = {2'b00, a[7:0]} + {{2{b[15]}}, b[7:0]} + {9'b0, cin};
    cout = s[LANE_W];
    sum  = s[LANE_W-1:0];
    case (mode)
      DMODE_INT8:   sum = {a[15:8], s8[9] ? 8'h00 : (s8[8] ? 8'hFF : s8[7:0])};
      DMODE_Z16SAT: sum = s[LANE_W] ? '1 : s[LANE_W-1:0];
      default:      sum = s[LANE_W-1:0];
    endcase
  end

endmodule

// File: rtl/dadd_unit.sv
// Blitter data-adder stage: Gouraud/Z iterators, four-lane saturating add and
// registered result for the data mux.
module dadd_unit
  import dadd_unit_pkg::*;
#(
  parameter int unsigned LANES = LANE_COUNT
) (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic [31:0] gpu_din,
  input  logic [1:0]  patf_ld,
  input  logic [1:0]  patd_ld,
  input  logic [1:0]  srcz2_ld,
  input  logic [1:0]  srcz1_ld,
  input  logic        iinc_ld,
  input  logic        zinc_ld,
  input  logic [63:0] srcd,
  input  logic [63:0] dstd,
  input  logic [2:0]  daddasel,
  input  logic [2:0]  daddbsel,
  input  logic [2:0]  daddmode,
  input  logic        daddq_sel,
  input  logic        patfadd,
  input  logic        patdadd,
  input  logic        srcz2add,
  input  logic        srcz1add,
  output logic [63:0] daddq,
  output logic        daddq_valid,
  output logic [63:0] patd,
  output logic [63:0] srcz1
);

  logic [63:0]      patf, srcz2;
  logic [31:0]      iinc, zinc;
  logic [LANES-1:0] cy, cout;
  logic [63:0]      a_op, b_op, sum;
  dmode_e           mode;
  logic             cin_en;
  wb_tgt_e          wb;

  always_comb begin
    a_op = dstd;
    if (!daddasel[2]) begin
      a_op = daddasel[0] ? srcd : dstd;
    end else begin
      case (daddasel)
        ASEL_PATF:  a_op = patf;
        ASEL_PATD:  a_op = patd;
        ASEL_SRCZ2: a_op = srcz2;
        default:    a_op = srcz1;
      endcase
    end
  end

  always_comb begin
    case (daddbsel)
      BSEL_SRCD:    b_op = srcd;
      BSEL_DSTD:    b_op = dstd;
      BSEL_IINC_LO: b_op = {LANES{iinc[15:0]}};
      BSEL_IINC_HI: b_op = {LANES{iinc[31:16]}};
      BSEL_ZINC_LO: b_op = {LANES{zinc[15:0]}};
      BSEL_ZINC_HI: b_op = {LANES{zinc[31:16]}};
      default:      b_op = '0;
    endcase
  end

  always_comb begin
    mode   = decode_mode(daddmode);
    cin_en = (mode != DMODE_FRAC);
    wb     = WB_NONE;
    if (daddq_sel) begin
      if (srcz1add)      wb = WB_SRCZ1;
      else if (srcz2add) wb = WB_SRCZ2;
      else if (patdadd)  wb = WB_PATD;
      else if (patfadd)  wb = WB_PATF;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dadd_lane u_lane (
      .a    (a_op[i*LANE_W +: LANE_W]),
      .b    (b_op[i*LANE_W +: LANE_W]),
      .cin  (cy[i] & cin_en),
      .mode (mode),
      .sum  (sum[i*LANE_W +: LANE_W]),
      .cout (cout[i])
    );
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      daddq       <= '0;
      daddq_valid <= 1'b0;
      patf        <= '0;
      patd        <= '0;
      srcz2       <= '0;
      srcz1       <= '0;
      iinc        <= '0;
      zinc        <= '0;
      cy          <= '0;
    end else begin
      daddq_valid <= daddq_sel;
      if (daddq_sel) begin
        daddq <= sum;
        cy    <= (mode == DMODE_FRAC) ? cout : '0;
      end
      patf  <= merge_halves(patf,  patf_ld,  gpu_din, wb == WB_PATF,  sum);
      patd  <= merge_halves(patd,  patd_ld,  gpu_din, wb == WB_PATD,  sum);
      srcz2 <= merge_halves(srcz2, srcz2_ld, gpu_din, wb == WB_SRCZ2, sum);
      srcz1 <= merge_halves(srcz1, srcz1_ld, gpu_din, wb == WB_SRCZ1, sum);
      if (iinc_ld) iinc <= gpu_din;
      if (zinc_ld) zinc <= gpu_din;
    end
  end

endmodule
